// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared definitions for the mux_rr registered multiplexer.
//               It holds the mode encodings and a modulo-N increment helper
//               that the round-robin pointer update uses.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Encodings for the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Returns (idx + 1) mod n and wraps explicitly from n-1 to 0. The
    // explicit wrap keeps the result correct when n is not a power of 2.
    function automatic int unsigned mod_inc(input int unsigned idx,
                                            input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational rotating-priority arbiter. It grants the
//               first requesting channel, searching from ptr_i upward and
//               wrapping modulo CHANNELS.
// Ports       : req_i         - per-channel request vector
//               ptr_i         - highest-priority channel index (< CHANNELS)
//               grant_valid_o - at least one request is present
//               grant_o       - index of the granted channel
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic                grant_valid_o,
    output logic [SEL_W-1:0]    grant_o
);

    // Channel index at rotation offset k from ptr. ptr is always below
    // CHANNELS, so a single conditional subtract performs the wrap.
    function automatic logic [SEL_W-1:0] rot_idx(input logic [SEL_W-1:0] ptr,
                                                 input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= CHANNELS) begin
            s = s - CHANNELS;
        end
        return SEL_W'(s);
    endfunction

    // The loop scans from the farthest offset down to offset 0. The last
    // match to be written is therefore the one nearest to ptr.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_o       = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req_i[rot_idx(ptr_i, k)]) begin
                grant_valid_o = 1'b1;
                grant_o       = rot_idx(ptr_i, k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr
// Description : N-channel registered multiplexer with a valid/ready output
//               stage. The channel is chosen by an explicit selector (fixed
//               mode) or by round-robin arbitration over valid channels.
// Ports       : clk         - clock, rising edge
//               reset       - synchronous active-high reset
//               mode        - 0 fixed select, 1 round-robin
//               selector    - channel index used in fixed mode
//               data_in     - packed channel data, ch i at [i*WIDTH +: WIDTH]
//               valid_in    - per-channel valid
//               ready_out   - per-channel accept strobe (one-hot or zero)
//               data_out    - registered selected data
//               channel_out - channel index of the word in data_out
//               valid_out   - data_out holds an unconsumed word
//               ready_in    - downstream consumes data_out this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    output logic [CHANNELS-1:0]       ready_out,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          channel_out,
    output logic                      valid_out,
    input  logic                      ready_in
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SEL_W-1:0] chan_q,  chan_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;

    logic             w_load;
    logic             w_fix_valid;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_grant;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant;
    logic [WIDTH-1:0] w_chan_data [CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_chan_data[gi] = data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The register can take a word when it is empty or when its word
    // leaves on this edge.
    assign w_load = !valid_q || ready_in;

    // The range check comes first so that a selector of CHANNELS or more
    // (possible when CHANNELS is not a power of 2) never indexes valid_in.
    assign w_fix_valid = (32'(selector) < CHANNELS) && valid_in[selector];

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req_i         (valid_in),
        .ptr_i         (ptr_q),
        .grant_valid_o (w_rr_valid),
        .grant_o       (w_rr_grant)
    );

    assign w_grant_valid = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;
    assign w_grant       = (mode == MODE_RR) ? w_rr_grant : selector;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign ready_out[gi] = w_load && w_grant_valid &&
                                   (w_grant == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (w_load) begin
            if (w_grant_valid) begin
                valid_d = 1'b1;
                data_d  = w_chan_data[w_grant];
                chan_d  = w_grant;
                // Only round-robin transfers move the pointer.
                if (mode == MODE_RR) begin
                    ptr_d = SEL_W'(mod_inc(32'(w_grant), CHANNELS));
                end
            end else begin
                // Data and channel keep their old values. Only valid drops.
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_out   = valid_q;
    assign data_out    = data_q;
    assign channel_out = chan_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr
// Description : Self-checking bench for mux_rr. It drives a table of
//               directed vectors into a 4-channel instance, then runs
//               hand-written sequences for mid-stream reset and a
//               3-channel instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        mode4;
    logic [1:0]  sel4;
    logic [31:0] din4;
    logic [3:0]  vin4;
    logic [3:0]  rout4;
    logic [7:0]  dout4;
    logic [1:0]  ch4;
    logic        vout4;
    logic        rin4;

    mux_rr #(.WIDTH(8), .CHANNELS(4)) u4 (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode4),
        .selector    (sel4),
        .data_in     (din4),
        .valid_in    (vin4),
        .ready_out   (rout4),
        .data_out    (dout4),
        .channel_out (ch4),
        .valid_out   (vout4),
        .ready_in    (rin4)
    );

    // 3-channel instance
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] din3;
    logic [2:0]  vin3;
    logic [2:0]  rout3;
    logic [7:0]  dout3;
    logic [1:0]  ch3;
    logic        vout3;
    logic        rin3;

    mux_rr #(.WIDTH(8), .CHANNELS(3)) u3 (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode3),
        .selector    (sel3),
        .data_in     (din3),
        .valid_in    (vin3),
        .ready_out   (rout3),
        .data_out    (dout3),
        .channel_out (ch3),
        .valid_out   (vout3),
        .ready_in    (rin3)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vin;
        logic       rin;
        logic [3:0] exp_ro;
        logic       exp_v;
        logic [7:0] exp_d;
        logic [1:0] exp_ch;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs [16];

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Channel data: ch3=D3 ch2=A5 ch1=B1 ch0=C0
        din4  = 32'hD3A5B1C0;
        din3  = 24'h332211;
        mode4 = 1'b0; sel4 = 2'd0; vin4 = 4'b0000; rin4 = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; vin3 = 3'b000;  rin3 = 1'b1;

        //          mode sel vin     rin  exp_ro   v  data   ch  ptr
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 2'd0};
        vecs[1]  = '{1'b0, 2'd3, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 2'd0};
        vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0, 2'd1};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 2'd2};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 2'd3};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 2'd0};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0, 2'd1};
        vecs[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 2'd0};
        vecs[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 2'd0};
        vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 2'd0};
        vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 2'd0};
        vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hD3, 2'd3, 2'd0};
        vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0, 2'd1};
        vecs[14] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 2'd1};
        vecs[15] = '{1'b0, 2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1, 2'd1};

        // Reset then idle
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid",   32'(vout4), 32'd0);
        check("rst_data",    32'(dout4), 32'd0);
        check("rst_channel", 32'(ch4),   32'd0);
        check("rst_ready",   32'(rout4), 32'd0);
        check("rst_ptr",     32'(u4.ptr_q), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_valid",  32'(vout4), 32'd0);
        check("idle_ready",  32'(rout4), 32'd0);

        // Table of directed vectors on the 4-channel instance
        for (int i = 0; i < 16; i++) begin
            mode4 = vecs[i].mode;
            sel4  = vecs[i].sel;
            vin4  = vecs[i].vin;
            rin4  = vecs[i].rin;
            #1;
            check($sformatf("v%0d_ready_out", i), 32'(rout4), 32'(vecs[i].exp_ro));
            tick();
            check($sformatf("v%0d_valid", i),   32'(vout4),    32'(vecs[i].exp_v));
            check($sformatf("v%0d_data", i),    32'(dout4),    32'(vecs[i].exp_d));
            check($sformatf("v%0d_channel", i), 32'(ch4),      32'(vecs[i].exp_ch));
            check($sformatf("v%0d_ptr", i),     32'(u4.ptr_q), 32'(vecs[i].exp_ptr));
        end

        // Mid-stream reset while FULL in round-robin mode with ptr=2
        mode4 = 1'b1; vin4 = 4'b0010; rin4 = 1'b1;
        tick();
        check("pre_rst_ptr",   32'(u4.ptr_q), 32'd2);
        check("pre_rst_valid", 32'(vout4),    32'd1);
        vin4  = 4'b1111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 32'(vout4),    32'd0);
        check("midrst_ptr",   32'(u4.ptr_q), 32'd0);
        check("midrst_data",  32'(dout4),    32'd0);
        #1;
        check("post_rst_ready", 32'(rout4), 32'b0001);
        tick();
        check("post_rst_channel", 32'(ch4),   32'd0);
        check("post_rst_data",    32'(dout4), 32'hC0);
        vin4 = 4'b0000;

        // 3-channel instance: out-of-range selector gives no grant
        mode3 = 1'b0; sel3 = 2'd3; vin3 = 3'b111; rin3 = 1'b1;
        #1;
        check("c3_sel3_ready", 32'(rout3), 32'd0);
        tick();
        check("c3_sel3_valid", 32'(vout3), 32'd0);

        // 3-channel round robin wraps 2 -> 0
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_ch;
            logic [7:0] exp_d;
            logic [2:0] exp_ro;
            exp_ch = 2'(i % 3);
            exp_d  = 8'h11 * (8'(i % 3) + 8'd1);
            exp_ro = 3'b001 << (i % 3);
            #1;
            check($sformatf("c3_rr%0d_ready", i), 32'(rout3), 32'(exp_ro));
            tick();
            check($sformatf("c3_rr%0d_channel", i), 32'(ch3),   32'(exp_ch));
            check($sformatf("c3_rr%0d_data", i),    32'(dout3), 32'(exp_d));
        end
        check("c3_ptr_after_wrap", 32'(u3.ptr_q), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
